// File: rtl/avalon_port_arbiter.sv
// Arbiter that shares one avalon_mm_master among three requesters (dbg, instr, ext).
// dbg has absolute priority; instr and ext alternate round-robin on simultaneous requests.
// A transaction runs IDLE -> ISSUE -> WAIT -> RESP. It is aborted to RESP with err when the
// WAIT phase lasts TIMEOUT cycles without m_done.
module avalon_port_arbiter #(
    parameter int unsigned width   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_dbg,
    input  logic             req_instr,
    input  logic             req_ext,
    input  logic             rnw_dbg,
    input  logic             rnw_instr,
    input  logic             rnw_ext,
    input  logic [width-1:0] addr_dbg,
    input  logic [width-1:0] addr_instr,
    input  logic [width-1:0] addr_ext,
    input  logic [width-1:0] wdata_dbg,
    input  logic [width-1:0] wdata_instr,
    input  logic [width-1:0] wdata_ext,
    output logic             done_dbg,
    output logic             done_instr,
    output logic             done_ext,
    output logic [width-1:0] rdata_dbg,
    output logic [width-1:0] rdata_instr,
    output logic [width-1:0] rdata_ext,
    output logic             err,
    output logic             m_start,
    output logic             m_rnw,
    output logic [width-1:0] m_address,
    output logic [width-1:0] m_wdata,
    input  logic             m_done,
    input  logic [width-1:0] m_rdata,
    output logic [1:0]       grant,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e           state_q, state_d;
    logic [1:0]       grant_q;
    logic             m_rnw_q;
    logic [width-1:0] m_address_q, m_wdata_q;
    logic [7:0]       cnt_q;
    logic             timeout_q;
    // 1: ext was granted last among instr/ext, 0: instr was.
    logic             last_ie_q;
    logic [width-1:0] rdata_dbg_q, rdata_instr_q, rdata_ext_q;

    logic             any_req;
    logic [1:0]       win;
    logic             sel_rnw;
    logic [width-1:0] sel_addr, sel_wdata;
    logic             timeout_hit;
    logic [2:0]       rd_load;
    logic [width-1:0] rd_val;

    assign any_req     = req_dbg | req_instr | req_ext;
    // The count after this WAIT cycle would equal TIMEOUT.
    assign timeout_hit = ((cnt_q + 8'd1) == TimeoutCnt);

    // Arbitration: pick the winner and mux its transfer attributes.
    always_comb begin
        win = 2'b00;
        if (req_dbg) begin
            win = 2'b01;
        end else if (req_instr && req_ext) begin
            win = last_ie_q ? 2'b10 : 2'b11;
        end else if (req_instr) begin
            win = 2'b10;
        end else if (req_ext) begin
            win = 2'b11;
        end
        sel_rnw   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (win)
            2'b01: begin
                sel_rnw   = rnw_dbg;
                sel_addr  = addr_dbg;
                sel_wdata = wdata_dbg;
            end
            2'b10: begin
                sel_rnw   = rnw_instr;
                sel_addr  = addr_instr;
                sel_wdata = wdata_instr;
            end
            2'b11: begin
                sel_rnw   = rnw_ext;
                sel_addr  = addr_ext;
                sel_wdata = wdata_ext;
            end
            default: begin
                sel_rnw   = 1'b0;
                sel_addr  = '0;
                sel_wdata = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; m_done is only honoured in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (m_done || timeout_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Transaction registers: grant, master request, WAIT counter, timeout flag, RR pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_q     <= 2'b00;
            m_rnw_q     <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
            cnt_q       <= 8'd0;
            timeout_q   <= 1'b0;
            last_ie_q   <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_q     <= win;
                        m_rnw_q     <= sel_rnw;
                        m_address_q <= sel_addr;
                        m_wdata_q   <= sel_wdata;
                        if (win[1]) last_ie_q <= win[0];
                    end
                end
                StIssue: begin
                    cnt_q     <= 8'd0;
                    timeout_q <= 1'b0;
                end
                StWait: begin
                    if (m_done) begin
                        timeout_q <= 1'b0;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    grant_q   <= 2'b00;
                    timeout_q <= 1'b0;
                end
                default: grant_q <= 2'b00;
            endcase
        end
    end

    // Read-data load select: reads only, m_rdata on completion, zero on timeout.
    always_comb begin
        rd_load = 3'b000;
        rd_val  = m_done ? m_rdata : '0;
        if (state_q == StWait && m_rnw_q && (m_done || timeout_hit)) begin
            case (grant_q)
                2'b01:   rd_load = 3'b001;
                2'b10:   rd_load = 3'b010;
                2'b11:   rd_load = 3'b100;
                default: rd_load = 3'b000;
            endcase
        end
    end

    // Per-port read-data holding registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_dbg_q   <= '0;
            rdata_instr_q <= '0;
            rdata_ext_q   <= '0;
        end else begin
            if (rd_load[0]) rdata_dbg_q   <= rd_val;
            if (rd_load[1]) rdata_instr_q <= rd_val;
            if (rd_load[2]) rdata_ext_q   <= rd_val;
        end
    end

    // Outputs decoded from state and registers.
    always_comb begin
        m_start     = (state_q == StIssue);
        busy        = (state_q != StIdle);
        done_dbg    = (state_q == StResp) && (grant_q == 2'b01);
        done_instr  = (state_q == StResp) && (grant_q == 2'b10);
        done_ext    = (state_q == StResp) && (grant_q == 2'b11);
        err         = (state_q == StResp) && timeout_q;
        grant       = grant_q;
        m_rnw       = m_rnw_q;
        m_address   = m_address_q;
        m_wdata     = m_wdata_q;
        rdata_dbg   = rdata_dbg_q;
        rdata_instr = rdata_instr_q;
        rdata_ext   = rdata_ext_q;
    end

endmodule
